sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that generalises the team's fixed 16x8 FIFO in width, depth and read mode. It adds occupancy count, almost-full/almost-empty thresholds, a synchronous flush, and correct over/underflow signalling. It sits between a producer and a consumer in the same clock domain and keeps the active-low read/write strobe convention, so existing benches and assertion binds port over with minimal change.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/sync_fifo_param_if.sv | 29 ++
 rtl/fifo_ram.sv | 17 +
 rtl/sync_fifo_param.sv | 75 +++++++
 tb/tb_sync_fifo_param.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and count sizing shared by the parametrised FIFO
package fifo_pkg;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer side of the FIFO, strobes active-low
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
);
  import fifo_pkg::*;
  localparam int CW = cnt_w(DEPTH);
  logic flush;
  logic wr_n;
  logic rd_n;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic rd_valid;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [CW-1:0] count;
  logic over_flow;
  logic under_flow;
  modport master(
    output flush, wr_n, rd_n, data_in,
    input data_out, rd_valid, full, empty, almost_full, almost_empty, count, over_flow, under_flow
  );
  modport slave(
    input flush, wr_n, rd_n, data_in,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count, over_flow, under_flow
  );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: storage array, synchronous write and asynchronous read, no reset
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [PW-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, threshold flags, flush
// and registered or first-word-fall-through read data.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = FIFO_STD
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] head, dout_q;
  logic full_q, empty_q, af_q, ae_q, ovf_q, udf_q, vld_q;
  logic wr_acc, rd_acc;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  // a read frees a slot in the same cycle, so a full FIFO still takes a write alongside it
  always_comb begin
    rd_acc = !bus.flush && !bus.rd_n && !empty_q;
    wr_acc = !bus.flush && !bus.wr_n && (!full_q || rd_acc);
    cnt_nxt = bus.flush ? '0 : cnt + CW'(wr_acc) - CW'(rd_acc);
  end
  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      af_q <= 1'b0;
      ae_q <= 1'b1;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      vld_q <= 1'b0;
      dout_q <= '0;
    end else begin
      wr_ptr <= bus.flush ? '0 : wr_acc ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= bus.flush ? '0 : rd_acc ? inc(rd_ptr) : rd_ptr;
      cnt <= cnt_nxt;
      full_q <= cnt_nxt == CW'(DEPTH);
      empty_q <= cnt_nxt == '0;
      af_q <= cnt_nxt >= CW'(AF_LEVEL);
      ae_q <= cnt_nxt <= CW'(AE_LEVEL);
      ovf_q <= !bus.flush && !bus.wr_n && !wr_acc;
      udf_q <= !bus.flush && !bus.rd_n && empty_q;
      vld_q <= rd_acc;
      dout_q <= rd_acc ? head : dout_q;
    end
  end
  // in FWFT the head is shown directly; masked to zero while empty so reset reads as 0
  assign bus.data_out = FWFT == FIFO_FWFT ? (empty_q ? '0 : head) : dout_q;
  assign bus.rd_valid = FWFT == FIFO_FWFT ? !empty_q : vld_q;
  assign bus.count = cnt;
  assign bus.full = full_q;
  assign bus.empty = empty_q;
  assign bus.almost_full = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.over_flow = ovf_q;
  assign bus.under_flow = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for a standard 16-deep FIFO and a 5-deep FWFT FIFO
module tb_sync_fifo_param;
  import fifo_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) a ();
  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(5)) b ();
  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(FIFO_STD)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave)
  );
  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(FIFO_FWFT)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wa(input logic [7:0] d);
    a.wr_n = 1'b0;
    a.data_in = d;
    tick();
    a.wr_n = 1'b1;
  endtask
  task automatic ra;
    a.rd_n = 1'b0;
    tick();
    a.rd_n = 1'b1;
  endtask
  task automatic wb(input logic [7:0] d);
    b.wr_n = 1'b0;
    b.data_in = d;
    tick();
    b.wr_n = 1'b1;
  endtask
  task automatic rb;
    b.rd_n = 1'b0;
    tick();
    b.rd_n = 1'b1;
  endtask
  task automatic test_reset;
    logic [19:0] st;
    #12;
    st = {a.count, a.empty, a.almost_empty, a.full, a.almost_full, a.over_flow, a.under_flow, a.rd_valid, a.data_out};
    total++;
    if (st !== {5'd0, 2'b11, 5'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_init got=%h exp=%h", st, {5'd0, 2'b11, 5'b0, 8'h00});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) wa(8'(8'h31 + i));
    ra();
    total++;
    if (a.count !== 5'd5 || a.data_out !== 8'h31) begin
      bad++;
      $display("FAIL pre_reset got=%0d/%h exp=5/31", a.count, a.data_out);
    end
    rst_n = 1'b0;
    #2;
    st = {a.count, a.empty, a.almost_empty, a.full, a.almost_full, a.over_flow, a.under_flow, a.rd_valid, a.data_out};
    total++;
    if (st !== {5'd0, 2'b11, 5'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=%h", st, {5'd0, 2'b11, 5'b0, 8'h00});
    end
    tick();
    rst_n = 1'b1;
    wa(8'hA5);
    ra();
    total++;
    if (a.data_out !== 8'hA5 || a.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_after got=%h/%b exp=a5/1", a.data_out, a.rd_valid);
    end
  endtask
  task automatic test_fill_drain;
    for (int i = 0; i < 16; i++) wa(8'(i));
    total++;
    if (a.full !== 1'b1 || a.count !== 5'd16 || a.almost_full !== 1'b1) begin
      bad++;
      $display("FAIL fill got=full%b cnt%0d af%b exp=1/16/1", a.full, a.count, a.almost_full);
    end
    wa(8'hEE);
    total++;
    if (a.over_flow !== 1'b1 || a.count !== 5'd16) begin
      bad++;
      $display("FAIL overflow got=%b/%0d exp=1/16", a.over_flow, a.count);
    end
    tick();
    total++;
    if (a.over_flow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_pulse got=%b exp=0", a.over_flow);
    end
    for (int i = 0; i < 16; i++) begin
      ra();
      total++;
      if (a.data_out !== 8'(i) || a.rd_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain%0d got=%h/%b exp=%h/1", i, a.data_out, a.rd_valid, 8'(i));
      end
    end
    total++;
    if (a.empty !== 1'b1 || a.count !== 5'd0) begin
      bad++;
      $display("FAIL drained got=%b/%0d exp=1/0", a.empty, a.count);
    end
  endtask
  task automatic test_boundaries;
    ra();
    total++;
    if (a.under_flow !== 1'b1 || a.data_out !== 8'h0F || a.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL underflow got=%b/%h/%b exp=1/0f/0", a.under_flow, a.data_out, a.rd_valid);
    end
    tick();
    total++;
    if (a.under_flow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_pulse got=%b exp=0", a.under_flow);
    end
    a.wr_n = 1'b0;
    a.rd_n = 1'b0;
    a.data_in = 8'h77;
    tick();
    a.wr_n = 1'b1;
    a.rd_n = 1'b1;
    total++;
    if (a.count !== 5'd1 || a.under_flow !== 1'b1 || a.empty !== 1'b0) begin
      bad++;
      $display("FAIL rw_empty got=%0d/%b/%b exp=1/1/0", a.count, a.under_flow, a.empty);
    end
    ra();
    total++;
    if (a.data_out !== 8'h77) begin
      bad++;
      $display("FAIL rw_empty_data got=%h exp=77", a.data_out);
    end
    for (int i = 0; i < 16; i++) wa(8'(8'h80 + i));
    a.wr_n = 1'b0;
    a.rd_n = 1'b0;
    a.data_in = 8'h55;
    tick();
    a.wr_n = 1'b1;
    a.rd_n = 1'b1;
    total++;
    if (a.count !== 5'd16 || a.over_flow !== 1'b0 || a.full !== 1'b1 || a.data_out !== 8'h80) begin
      bad++;
      $display("FAIL rw_full got=%0d/%b/%b/%h exp=16/0/1/80", a.count, a.over_flow, a.full, a.data_out);
    end
    for (int i = 0; i < 16; i++) begin
      ra();
      total++;
      if (a.data_out !== (i < 15 ? 8'(8'h81 + i) : 8'h55)) begin
        bad++;
        $display("FAIL rw_full_drain%0d got=%h exp=%h", i, a.data_out, i < 15 ? 8'(8'h81 + i) : 8'h55);
      end
    end
  endtask
  task automatic test_wrap_thresholds;
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] d;
    int mcnt = 0;
    bit do_w, do_r;
    for (int i = 0; i < 40; i++) begin
      do_w = i < 15 || i >= 29;
      do_r = (i >= 15 && i < 29) || (i >= 29 && i % 2 == 1);
      d = 8'(i * 7 + 3);
      a.wr_n = !do_w;
      a.rd_n = !do_r;
      a.data_in = d;
      exp_d = 8'h00;
      if (do_r) exp_d = q.pop_front();
      if (do_w) q.push_back(d);
      mcnt = mcnt + int'(do_w) - int'(do_r);
      tick();
      a.wr_n = 1'b1;
      a.rd_n = 1'b1;
      total++;
      if (a.count !== 5'(mcnt) || a.almost_full !== (mcnt >= 14) || a.almost_empty !== (mcnt <= 2)) begin
        bad++;
        $display("FAIL wrap_flags%0d got=%0d/%b/%b exp=%0d/%b/%b", i, a.count, a.almost_full, a.almost_empty, mcnt, mcnt >= 14, mcnt <= 2);
      end
      if (do_r) begin
        total++;
        if (a.data_out !== exp_d) begin
          bad++;
          $display("FAIL wrap_data%0d got=%h exp=%h", i, a.data_out, exp_d);
        end
      end
    end
    while (q.size() > 0) begin
      exp_d = q.pop_front();
      ra();
      total++;
      if (a.data_out !== exp_d) begin
        bad++;
        $display("FAIL wrap_tail got=%h exp=%h", a.data_out, exp_d);
      end
    end
  endtask
  task automatic test_flush;
    for (int i = 0; i < 9; i++) wa(8'(8'hC0 + i));
    total++;
    if (a.count !== 5'd9) begin
      bad++;
      $display("FAIL flush_pre got=%0d exp=9", a.count);
    end
    a.flush = 1'b1;
    a.wr_n = 1'b0;
    a.rd_n = 1'b0;
    a.data_in = 8'hCC;
    tick();
    a.flush = 1'b0;
    a.wr_n = 1'b1;
    a.rd_n = 1'b1;
    total++;
    if (a.count !== 5'd0 || a.empty !== 1'b1 || a.over_flow !== 1'b0 || a.under_flow !== 1'b0 || a.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush got=%0d/%b/%b/%b/%b exp=0/1/0/0/0", a.count, a.empty, a.over_flow, a.under_flow, a.rd_valid);
    end
    wa(8'h3C);
    total++;
    if (a.count !== 5'd1 || a.under_flow !== 1'b0) begin
      bad++;
      $display("FAIL flush_wr got=%0d/%b exp=1/0", a.count, a.under_flow);
    end
    ra();
    total++;
    if (a.data_out !== 8'h3C || a.empty !== 1'b1) begin
      bad++;
      $display("FAIL flush_rd got=%h/%b exp=3c/1", a.data_out, a.empty);
    end
  endtask
  task automatic test_fwft;
    total++;
    if (b.data_out !== 8'h00 || b.rd_valid !== 1'b0 || b.empty !== 1'b1) begin
      bad++;
      $display("FAIL fwft_idle got=%h/%b/%b exp=00/0/1", b.data_out, b.rd_valid, b.empty);
    end
    wb(8'h11);
    total++;
    if (b.data_out !== 8'h11 || b.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL fwft_first got=%h/%b exp=11/1", b.data_out, b.rd_valid);
    end
    wb(8'h22);
    total++;
    if (b.data_out !== 8'h11 || b.count !== 3'd2) begin
      bad++;
      $display("FAIL fwft_second got=%h/%0d exp=11/2", b.data_out, b.count);
    end
    rb();
    total++;
    if (b.data_out !== 8'h22 || b.count !== 3'd1 || b.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL fwft_pop got=%h/%0d/%b exp=22/1/1", b.data_out, b.count, b.rd_valid);
    end
    for (int i = 0; i < 4; i++) wb(8'(8'h33 + 8'h11 * i));
    total++;
    if (b.full !== 1'b1 || b.count !== 3'd5 || b.data_out !== 8'h22) begin
      bad++;
      $display("FAIL fwft_full got=%b/%0d/%h exp=1/5/22", b.full, b.count, b.data_out);
    end
    for (int i = 0; i < 4; i++) begin
      rb();
      total++;
      if (b.data_out !== 8'(8'h33 + 8'h11 * i)) begin
        bad++;
        $display("FAIL fwft_drain%0d got=%h exp=%h", i, b.data_out, 8'(8'h33 + 8'h11 * i));
      end
    end
    rb();
    total++;
    if (b.empty !== 1'b1 || b.rd_valid !== 1'b0 || b.data_out !== 8'h00) begin
      bad++;
      $display("FAIL fwft_empty got=%b/%b/%h exp=1/0/00", b.empty, b.rd_valid, b.data_out);
    end
  endtask
  initial begin
    a.flush = 1'b0;
    a.wr_n = 1'b1;
    a.rd_n = 1'b1;
    a.data_in = 8'h00;
    b.flush = 1'b0;
    b.wr_n = 1'b1;
    b.rd_n = 1'b1;
    b.data_in = 8'h00;
    test_reset();
    test_fill_drain();
    test_boundaries();
    test_wrap_thresholds();
    test_flush();
    test_fwft();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
